// File: rtl/mem_responder_if.sv
// Data-memory bus between the MR/MW pipeline stages (master) and the memory responder (slave).
interface mem_responder_if;
  logic        re;
  logic [31:0] r_addr;
  logic [31:0] d_out;
  logic        r_finished;
  logic        we;
  logic [31:0] w_addr;
  logic [31:0] d_in;
  logic        w_finished;

  modport master (
    output re, r_addr, we, w_addr, d_in,
    input  d_out, r_finished, w_finished
  );

  modport slave (
    input  re, r_addr, we, w_addr, d_in,
    output d_out, r_finished, w_finished
  );
endinterface

// File: rtl/mem_responder.sv
// Data-memory responder: independent read/write ports with programmable latency sharing one
// single-ported word array, write port has priority when both are ready on the same edge.
module mem_responder #(
  parameter int unsigned RD_LAT    = 3,
  parameter int unsigned WR_LAT    = 4,
  parameter int unsigned ADDR_BITS = 10
) (
  input logic             clk,
  input logic             r,
  mem_responder_if.slave  bus
);

  localparam int unsigned Depth     = 2 ** ADDR_BITS;
  localparam logic [3:0]  RdCntInit = 4'(RD_LAT - 1);
  localparam logic [3:0]  WrCntInit = 4'(WR_LAT - 1);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e                rd_state_q, wr_state_q;
  logic [3:0]            rd_cnt_q, wr_cnt_q;
  logic [ADDR_BITS-1:0]  rd_idx_q, wr_idx_q;
  logic [31:0]           wr_data_q;
  logic [31:0]           d_out_q;
  logic                  r_fin_q, w_fin_q;
  logic [31:0]           mem_q [Depth];

  logic rd_ready, wr_ready, rd_grant, wr_grant;

  // A port is ready only while its request is still held; a dropped request is an abort.
  always_comb begin
    wr_ready = (wr_state_q == StBusy) && (wr_cnt_q == 4'd0) && bus.we;
    rd_ready = (rd_state_q == StBusy) && (rd_cnt_q == 4'd0) && bus.re;
    wr_grant = wr_ready;
    rd_grant = rd_ready && !wr_ready;
  end

  always_ff @(posedge clk) begin
    if (r) begin
      rd_state_q <= StIdle;
      wr_state_q <= StIdle;
      rd_cnt_q   <= 4'd0;
      wr_cnt_q   <= 4'd0;
      r_fin_q    <= 1'b0;
      w_fin_q    <= 1'b0;
      d_out_q    <= 32'd0;
    end else begin
      r_fin_q <= 1'b0;
      w_fin_q <= 1'b0;

      case (wr_state_q)
        StIdle: begin
          if (bus.we) begin
            wr_state_q <= StBusy;
            wr_idx_q   <= bus.w_addr[ADDR_BITS+1:2];
            wr_data_q  <= bus.d_in;
            wr_cnt_q   <= WrCntInit;
          end
        end
        StBusy: begin
          if (!bus.we) begin
            wr_state_q <= StIdle;
          end else if (wr_cnt_q != 4'd0) begin
            wr_cnt_q <= wr_cnt_q - 4'd1;
          end else if (wr_grant) begin
            wr_state_q <= StDone;
            w_fin_q    <= 1'b1;
          end
        end
        StDone:  wr_state_q <= StIdle;
        default: wr_state_q <= StIdle;
      endcase

      case (rd_state_q)
        StIdle: begin
          if (bus.re) begin
            rd_state_q <= StBusy;
            rd_idx_q   <= bus.r_addr[ADDR_BITS+1:2];
            rd_cnt_q   <= RdCntInit;
          end
        end
        StBusy: begin
          if (!bus.re) begin
            rd_state_q <= StIdle;
          end else if (rd_cnt_q != 4'd0) begin
            rd_cnt_q <= rd_cnt_q - 4'd1;
          end else if (rd_grant) begin
            rd_state_q <= StDone;
            r_fin_q    <= 1'b1;
            d_out_q    <= mem_q[rd_idx_q];
          end
        end
        StDone:  rd_state_q <= StIdle;
        default: rd_state_q <= StIdle;
      endcase
    end
  end

  // Array has no reset; a write granted on a reset edge is discarded.
  always_ff @(posedge clk) begin
    if (wr_grant && !r) begin
      mem_q[wr_idx_q] <= wr_data_q;
    end
  end

  assign bus.d_out      = d_out_q;
  assign bus.r_finished = r_fin_q;
  assign bus.w_finished = w_fin_q;

  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.r_addr, bus.w_addr};

endmodule

// File: tb/tb_mem_responder.sv
// Directed + randomized bench for mem_responder against a cycle-timed transaction model.
module tb_mem_responder;

  localparam int unsigned RdLat    = 3;
  localparam int unsigned WrLat    = 4;
  localparam int unsigned AddrBits = 10;
  localparam int unsigned Words    = 1 << AddrBits;

  logic clk = 1'b0;
  logic r;
  always #5 clk = ~clk;

  mem_responder_if bus();

  mem_responder #(
    .RD_LAT   (RdLat),
    .WR_LAT   (WrLat),
    .ADDR_BITS(AddrBits)
  ) dut (
    .clk(clk),
    .r  (r),
    .bus(bus)
  );

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] ref_mem [Words];
  logic [31:0] last_dout;

  function automatic int widx(input logic [31:0] a);
    return int'((a >> 2) % Words);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One transaction window: optional write starting in cycle ws, optional read in cycle rs.
  // Each port completes LAT+1 cycles after its start; a read whose grant cycle coincides
  // with the write's loses one cycle, and sees the new data if it is granted afterwards.
  task automatic xact(input bit dw, input bit dr, input bit hold_r, input int ws, input int rs,
                      input logic [31:0] wa, input logic [31:0] wd, input logic [31:0] ra);
    int          wg, rg, last;
    logic [31:0] rdata;
    wg = ws + int'(WrLat);
    rg = rs + int'(RdLat);
    if (dw && dr && rg == wg) rg++;
    rdata = ref_mem[widx(ra)];
    if (dw && dr && rg > wg && widx(ra) == widx(wa)) rdata = wd;
    last = 0;
    if (dw) last = wg + 2;
    if (dr && rg + 2 > last) last = rg + 2;
    for (int c = 0; c <= last; c++) begin
      chk("w_finished", {31'b0, bus.w_finished}, {31'b0, (dw && c == wg + 1)});
      chk("r_finished", {31'b0, bus.r_finished}, {31'b0, (dr && c == rg + 1)});
      chk("d_out", bus.d_out, (dr && c > rg) ? rdata : last_dout);
      if (dw) begin
        if (c == ws) begin
          bus.we = 1'b1; bus.w_addr = wa; bus.d_in = wd;
        end else if (c > ws && c <= wg) begin
          bus.w_addr = $urandom; bus.d_in = $urandom;
        end else if (c == wg + 1) begin
          bus.we = 1'b0;
        end
      end
      if (dr) begin
        if (c == rs) begin
          bus.re = 1'b1; bus.r_addr = ra;
        end else if (c > rs && c <= rg) begin
          bus.r_addr = $urandom;
        end else if (c == rg + 1 && !hold_r) begin
          bus.re = 1'b0;
        end
      end
      if (c < last) step();
    end
    if (dw) ref_mem[widx(wa)] = wd;
    if (dr) last_dout = rdata;
  endtask

  // Both ports accept and then drop their request while still busy: nothing may complete.
  task automatic aborts(input int rdrop, input int wdrop, input logic [31:0] ra,
                        input logic [31:0] wa, input logic [31:0] wd);
    int last;
    last = int'(WrLat) + 3;
    for (int c = 0; c <= last; c++) begin
      chk("abort r_finished", {31'b0, bus.r_finished}, 32'd0);
      chk("abort w_finished", {31'b0, bus.w_finished}, 32'd0);
      chk("abort d_out", bus.d_out, last_dout);
      if (c == 0) begin
        bus.re = 1'b1; bus.r_addr = ra;
        bus.we = 1'b1; bus.w_addr = wa; bus.d_in = wd;
      end
      if (c == rdrop) bus.re = 1'b0;
      if (c == wdrop) bus.we = 1'b0;
      if (c < last) step();
    end
  endtask

  initial begin
    for (int i = 0; i < int'(Words); i++) ref_mem[i] = 32'd0;
    last_dout  = 32'd0;
    r          = 1'b1;
    bus.re     = 1'b1;
    bus.we     = 1'b1;
    bus.r_addr = 32'h0;
    bus.w_addr = 32'h8;
    bus.d_in   = 32'h55;

    // Reset held two cycles with both requests high
    for (int i = 0; i < 2; i++) begin
      step();
      chk("rst r_finished", {31'b0, bus.r_finished}, 32'd0);
      chk("rst w_finished", {31'b0, bus.w_finished}, 32'd0);
      chk("rst d_out", bus.d_out, 32'd0);
    end
    r = 1'b0;
    xact(1'b1, 1'b1, 1'b0, 0, 0, 32'h8, 32'h55, 32'h0);

    // Write then read with an unaligned address of the same word
    xact(1'b1, 1'b0, 1'b0, 0, 0, 32'h40, 32'hDEADBEEF, 32'h0);
    xact(1'b0, 1'b1, 1'b0, 0, 0, 32'h0, 32'h0, 32'h43);

    // Collision: both at cnt=0 together, read waits and sees the new data
    xact(1'b1, 1'b1, 1'b0, 0, 1, 32'h80, 32'h12345678, 32'h80);

    // Aborts, including a drop exactly on the would-be grant edge
    aborts(2, 2, 32'h80, 32'h10, 32'h1);
    xact(1'b0, 1'b1, 1'b0, 0, 0, 32'h0, 32'h0, 32'h10);
    aborts(int'(RdLat), int'(WrLat), 32'h40, 32'h10, 32'h2);
    xact(1'b0, 1'b1, 1'b0, 0, 0, 32'h0, 32'h0, 32'h10);

    // Alias and back-to-back reads with re held through DONE
    xact(1'b1, 1'b0, 1'b0, 0, 0, 32'h1000, 32'hA5A5A5A5, 32'h0);
    xact(1'b0, 1'b1, 1'b1, 0, 0, 32'h0, 32'h0, 32'h0);
    xact(1'b0, 1'b1, 1'b0, 0, 0, 32'h0, 32'h0, 32'h4);

    // Reset in cycle 3 of a write discards it and clears d_out
    bus.we = 1'b1; bus.w_addr = 32'h20; bus.d_in = 32'hCAFEF00D;
    for (int c = 0; c < 3; c++) begin
      chk("mid w_finished", {31'b0, bus.w_finished}, 32'd0);
      step();
    end
    r = 1'b1; bus.we = 1'b0;
    step();
    r = 1'b0;
    last_dout = 32'd0;
    for (int c = 0; c < int'(WrLat) + 2; c++) begin
      chk("post-rst w_finished", {31'b0, bus.w_finished}, 32'd0);
      chk("post-rst d_out", bus.d_out, 32'd0);
      step();
    end
    xact(1'b0, 1'b1, 1'b0, 0, 0, 32'h0, 32'h0, 32'h20);

    // Randomized transactions over a small aliased word pool
    for (int i = 0; i < 40; i++) begin
      bit          dw, dr;
      int          ws, rs;
      logic [31:0] wa, ra;
      dw = 1'($urandom_range(0, 1));
      dr = dw ? 1'($urandom_range(0, 1)) : 1'b1;
      ws = int'($urandom_range(0, 4));
      rs = int'($urandom_range(0, 4));
      wa = ($urandom & 32'hFFFF_F003) | (32'($urandom_range(0, 7)) << 2);
      ra = ($urandom & 32'hFFFF_F003) | (32'($urandom_range(0, 7)) << 2);
      xact(dw, dr, 1'b0, ws, rs, wa, $urandom, ra);
      if (i % 8 == 7) begin
        aborts(int'($urandom_range(1, RdLat)), int'($urandom_range(1, WrLat)), ra, wa,
               $urandom);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
